// File: rtl/char_sequencer_if.sv
// Host write channel for the character sequencer's message buffer.
// The master appends one ASCII code per accepted valid/ready handshake.
interface char_sequencer_if;
    logic       wr_valid;
    logic [6:0] wr_char;
    logic       wr_ready;

    modport master (output wr_valid, output wr_char, input wr_ready);
    modport slave  (input wr_valid, input wr_char, output wr_ready);
endinterface

// File: rtl/char_sequencer.sv
// Steps through a buffered ASCII message and shows one glyph at a time.
// Outputs change only on the vsync falling edge, so a glyph never changes mid-frame.
module char_sequencer #(
    parameter int DEPTH           = 32,
    parameter int FRAMES_PER_CHAR = 30,
    parameter int X_START         = 144,
    parameter int Y_START         = 35,
    parameter int X_END           = 784,
    parameter int Y_END           = 515,
    parameter int CHAR_W          = 16,
    parameter int CHAR_H          = 16
) (
    input  logic                     pix_clk,
    input  logic                     rst,
    input  logic                     VS_in,
    char_sequencer_if.slave          wr_if,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    output logic [6:0]               char_sel,
    output logic [9:0]               x_pos,
    output logic [9:0]               y_pos,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FRAMES_PER_CHAR + 1);

    localparam logic [9:0]    X_S    = 10'(X_START);
    localparam logic [9:0]    Y_S    = 10'(Y_START);
    localparam logic [10:0]   X_E    = 11'(X_END);
    localparam logic [10:0]   Y_E    = 11'(Y_END);
    localparam logic [10:0]   GW     = 11'(CHAR_W);
    localparam logic [10:0]   GH     = 11'(CHAR_H);
    localparam logic [FW-1:0] F_LAST = FW'(FRAMES_PER_CHAR - 1);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
    localparam logic [6:0]    BLANK  = 7'h20;

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_FINISH} state_t;

    state_t          r_state, w_state_next;
    logic            r_vs_prev;
    logic            w_tick;
    logic [6:0]      r_mem [DEPTH];
    logic [CW-1:0]   r_count, w_count_next;
    logic [AW-1:0]   r_rd_idx, w_rd_idx_next, w_rd_inc;
    logic [FW-1:0]   r_frame_cnt, w_frame_cnt_next;
    logic [6:0]      r_char, w_char_next;
    logic [9:0]      r_x, r_y, w_x_next, w_y_next;
    logic [9:0]      w_x_adv, w_y_adv;
    logic [10:0]     w_x_sum, w_y_sum;
    logic            w_wr_fire;
    logic            w_last;

    assign w_tick         = r_vs_prev & ~VS_in;
    assign wr_if.wr_ready = (r_state == S_IDLE) && (r_count < C_FULL) && !start && !clear;
    assign w_wr_fire      = wr_if.wr_valid && wr_if.wr_ready;
    assign w_rd_inc       = r_rd_idx + 1'b1;
    assign w_last         = ({1'b0, r_rd_idx} + 1'b1) >= r_count;

    // Next glyph cell: wrap to a new row when the following cell would overrun the line
    always_comb begin
        w_x_sum = {1'b0, r_x} + GW;
        w_y_sum = {1'b0, r_y} + GH;
        w_x_adv = w_x_sum[9:0];
        w_y_adv = r_y;
        if (w_x_sum + GW > X_E) begin
            w_x_adv = X_S;
            w_y_adv = (w_y_sum + GH > Y_E) ? Y_S : w_y_sum[9:0];
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_count_next     = r_count;
        w_rd_idx_next    = r_rd_idx;
        w_frame_cnt_next = r_frame_cnt;
        w_char_next      = r_char;
        w_x_next         = r_x;
        w_y_next         = r_y;
        case (r_state)
            S_IDLE: begin
                if (clear) begin
                    w_count_next = '0;
                end else begin
                    if (w_wr_fire) begin
                        w_count_next = r_count + 1'b1;
                    end
                    if (start && (r_count != '0)) begin
                        w_state_next     = S_SHOW;
                        w_rd_idx_next    = '0;
                        w_frame_cnt_next = '0;
                        w_char_next      = r_mem[0];
                        w_x_next         = X_S;
                        w_y_next         = Y_S;
                    end
                end
            end
            S_SHOW: begin
                if (stop) begin
                    w_state_next = S_IDLE;
                end else if (w_tick) begin
                    if (r_frame_cnt != F_LAST) begin
                        w_frame_cnt_next = r_frame_cnt + 1'b1;
                    end else begin
                        w_frame_cnt_next = '0;
                        if (!w_last) begin
                            w_rd_idx_next = w_rd_inc;
                            w_char_next   = r_mem[w_rd_inc];
                            w_x_next      = w_x_adv;
                            w_y_next      = w_y_adv;
                        end else if (loop_en) begin
                            w_rd_idx_next = '0;
                            w_char_next   = r_mem[0];
                            w_x_next      = X_S;
                            w_y_next      = Y_S;
                        end else begin
                            w_state_next = S_FINISH;
                        end
                    end
                end
            end
            S_FINISH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pix_clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_vs_prev   <= 1'b0;
            r_count     <= '0;
            r_rd_idx    <= '0;
            r_frame_cnt <= '0;
            r_char      <= BLANK;
            r_x         <= X_S;
            r_y         <= Y_S;
        end else begin
            r_state     <= w_state_next;
            r_vs_prev   <= VS_in;
            r_count     <= w_count_next;
            r_rd_idx    <= w_rd_idx_next;
            r_frame_cnt <= w_frame_cnt_next;
            r_char      <= w_char_next;
            r_x         <= w_x_next;
            r_y         <= w_y_next;
        end
    end

    // Message storage carries no reset; only entries below count are ever read
    always_ff @(posedge pix_clk) begin
        if (w_wr_fire) begin
            r_mem[r_count[AW-1:0]] <= wr_if.wr_char;
        end
    end

    assign char_sel = r_char;
    assign x_pos    = r_x;
    assign y_pos    = r_y;
    assign busy     = (r_state == S_SHOW);
    assign done     = (r_state == S_FINISH);
    assign count    = r_count;
endmodule

// File: tb/tb_char_sequencer.sv
// Scoreboard bench: three sequencer instances with different geometry; each display change is
// popped from a per-instance queue of expected {busy,done,char,x,y} and compared.
module tb_char_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic       vs  [3];
    logic       clr [3];
    logic       stt [3];
    logic       stp [3];
    logic       lp  [3];
    logic [6:0] char_sel [3];
    logic [9:0] x_pos [3];
    logic [9:0] y_pos [3];
    logic       busy [3];
    logic       done [3];
    logic [5:0] cnt0;
    logic [6:0] cnt1;
    logic [3:0] cnt2;

    char_sequencer_if wif0 ();
    char_sequencer_if wif1 ();
    char_sequencer_if wif2 ();

    char_sequencer #(.DEPTH(32), .FRAMES_PER_CHAR(2)) dut0 (
        .pix_clk(clk), .rst(rst), .VS_in(vs[0]), .wr_if(wif0),
        .clear(clr[0]), .start(stt[0]), .stop(stp[0]), .loop_en(lp[0]),
        .char_sel(char_sel[0]), .x_pos(x_pos[0]), .y_pos(y_pos[0]),
        .busy(busy[0]), .done(done[0]), .count(cnt0)
    );
    char_sequencer #(.DEPTH(64), .FRAMES_PER_CHAR(1)) dut1 (
        .pix_clk(clk), .rst(rst), .VS_in(vs[1]), .wr_if(wif1),
        .clear(clr[1]), .start(stt[1]), .stop(stp[1]), .loop_en(lp[1]),
        .char_sel(char_sel[1]), .x_pos(x_pos[1]), .y_pos(y_pos[1]),
        .busy(busy[1]), .done(done[1]), .count(cnt1)
    );
    char_sequencer #(.DEPTH(8), .FRAMES_PER_CHAR(1), .X_END(176), .Y_END(67)) dut2 (
        .pix_clk(clk), .rst(rst), .VS_in(vs[2]), .wr_if(wif2),
        .clear(clr[2]), .start(stt[2]), .stop(stp[2]), .loop_en(lp[2]),
        .char_sel(char_sel[2]), .x_pos(x_pos[2]), .y_pos(y_pos[2]),
        .busy(busy[2]), .done(done[2]), .count(cnt2)
    );

    // Packed display word: {busy, done, char[6:0], x[9:0], y[9:0]}
    logic [28:0] obs [3];
    logic [28:0] exp_q [3][$];
    logic        mon_en = 1'b0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_mon
        logic [28:0] prev;
        logic [28:0] e;
        assign obs[gi] = {busy[gi], done[gi], char_sel[gi], x_pos[gi], y_pos[gi]};
        always @(negedge clk) begin
            if (!mon_en) begin
                prev <= obs[gi];
            end else if (obs[gi] !== prev) begin
                prev <= obs[gi];
                vectors++;
                if (exp_q[gi].size() == 0) begin
                    miscompares++;
                    $display("FAIL dut%0d unexpected_event: got busy=%b done=%b char=%h x=%0d y=%0d, required no change",
                             gi, obs[gi][28], obs[gi][27], obs[gi][26:20], obs[gi][19:10], obs[gi][9:0]);
                end else begin
                    e = exp_q[gi].pop_front();
                    if (e !== obs[gi]) begin
                        miscompares++;
                        $display("FAIL dut%0d display_event: got busy=%b done=%b char=%h x=%0d y=%0d, required busy=%b done=%b char=%h x=%0d y=%0d",
                                 gi, obs[gi][28], obs[gi][27], obs[gi][26:20], obs[gi][19:10], obs[gi][9:0],
                                 e[28], e[27], e[26:20], e[19:10], e[9:0]);
                    end else begin
                        $display("dut%0d event ok: busy=%b done=%b char=%h x=%0d y=%0d",
                                 gi, e[28], e[27], e[26:20], e[19:10], e[9:0]);
                    end
                end
            end
        end
    end

    function automatic logic [28:0] pk(input logic b, input logic d, input logic [6:0] c,
                                       input int x, input int y);
        return {b, d, c, 10'(x), 10'(y)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end else begin
            $display("check %s ok: %0d", name, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int d, input logic [6:0] c, output logic acc);
        case (d)
            0: begin wif0.wr_valid = 1'b1; wif0.wr_char = c; end
            1: begin wif1.wr_valid = 1'b1; wif1.wr_char = c; end
            default: begin wif2.wr_valid = 1'b1; wif2.wr_char = c; end
        endcase
        @(negedge clk);
        case (d)
            0: acc = wif0.wr_ready;
            1: acc = wif1.wr_ready;
            default: acc = wif2.wr_ready;
        endcase
        step(1);
        wif0.wr_valid = 1'b0;
        wif1.wr_valid = 1'b0;
        wif2.wr_valid = 1'b0;
    endtask

    task automatic vs_fall(input int d, input int post);
        vs[d] = 1'b0;
        step(1);
        vs[d] = 1'b1;
        step(post);
    endtask

    task automatic pulse_start(input int d);
        stt[d] = 1'b1;
        step(1);
        stt[d] = 1'b0;
        step(1);
    endtask

    task automatic wait_done(input int d);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = done[d];
        end
        chk($sformatf("dut%0d_done_pulse", d), 32'(seen), 32'd1);
        @(negedge clk);
        chk($sformatf("dut%0d_done_one_cycle", d), 32'(done[d]), 32'd0);
        chk($sformatf("dut%0d_busy_after_done", d), 32'(busy[d]), 32'd0);
        step(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        logic [6:0] c;
        int n_acc;
        int xs [5] = '{144, 160, 144, 160, 144};
        int ys [5] = '{35, 35, 51, 51, 35};

        for (int d = 0; d < 3; d++) begin
            vs[d] = 1'b1; clr[d] = 1'b0; stt[d] = 1'b0; stp[d] = 1'b0; lp[d] = 1'b0;
        end
        wif0.wr_valid = 1'b0; wif0.wr_char = '0;
        wif1.wr_valid = 1'b0; wif1.wr_char = '0;
        wif2.wr_valid = 1'b0; wif2.wr_char = '0;

        // Reset held with random activity on dut0
        repeat (8) begin
            @(posedge clk); #1;
            vs[0] = 1'($urandom); clr[0] = 1'($urandom); stt[0] = 1'($urandom);
            stp[0] = 1'($urandom); lp[0] = 1'($urandom);
            wif0.wr_valid = 1'($urandom); wif0.wr_char = 7'($urandom);
        end
        @(negedge clk);
        chk("rst_char_sel", 32'(char_sel[0]), 32'h20);
        chk("rst_x_pos", 32'(x_pos[0]), 32'd144);
        chk("rst_y_pos", 32'(y_pos[0]), 32'd35);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_done", 32'(done[0]), 32'd0);
        chk("rst_count", 32'(cnt0), 32'd0);
        @(posedge clk); #1;
        vs[0] = 1'b1; clr[0] = 1'b0; stt[0] = 1'b0; stp[0] = 1'b0; lp[0] = 1'b0;
        wif0.wr_valid = 1'b0;
        step(1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_release_wr_ready", 32'(wif0.wr_ready), 32'd1);
        mon_en = 1'b1;
        step(1);

        // Basic three-glyph sequence, two frames per glyph
        wr(0, 7'h41, acc); wr(0, 7'h42, acc); wr(0, 7'h43, acc);
        chk("basic_count", 32'(cnt0), 32'd3);
        exp_q[0].push_back(pk(1, 0, 7'h41, 144, 35));
        pulse_start(0);
        exp_q[0].push_back(pk(1, 0, 7'h42, 160, 35));
        vs_fall(0, 2); vs_fall(0, 2);
        exp_q[0].push_back(pk(1, 0, 7'h43, 176, 35));
        vs_fall(0, 2); vs_fall(0, 2);
        exp_q[0].push_back(pk(0, 1, 7'h43, 176, 35));
        exp_q[0].push_back(pk(0, 0, 7'h43, 176, 35));
        vs_fall(0, 2);
        vs_fall(0, 0);
        wait_done(0);
        chk("basic_count_kept", 32'(cnt0), 32'd3);

        // Priorities in IDLE: vsync ignored, clear beats start, empty start ignored
        vs_fall(0, 3);
        wr(0, 7'h44, acc); wr(0, 7'h45, acc);
        chk("prio_count5", 32'(cnt0), 32'd5);
        clr[0] = 1'b1; stt[0] = 1'b1;
        step(1);
        clr[0] = 1'b0; stt[0] = 1'b0;
        step(1);
        chk("prio_clear_wins_count", 32'(cnt0), 32'd0);
        chk("prio_clear_wins_busy", 32'(busy[0]), 32'd0);
        pulse_start(0);
        chk("prio_empty_start_busy", 32'(busy[0]), 32'd0);

        // Fill the buffer
        n_acc = 0;
        for (int i = 0; i < 32; i++) begin
            wr(0, 7'(8'h30 + i), acc);
            n_acc += int'(acc);
        end
        chk("full_accepted", 32'(n_acc), 32'd32);
        chk("full_count", 32'(cnt0), 32'd32);
        @(negedge clk);
        chk("full_wr_ready", 32'(wif0.wr_ready), 32'd0);
        step(1);
        wr(0, 7'h7a, acc);
        chk("full_33rd_rejected", 32'(acc), 32'd0);
        chk("full_count_held", 32'(cnt0), 32'd32);

        // Looping two-glyph message, then stop
        clr[0] = 1'b1; step(1); clr[0] = 1'b0;
        wr(0, 7'h58, acc); wr(0, 7'h59, acc);
        chk("loop_count", 32'(cnt0), 32'd2);
        lp[0] = 1'b1;
        exp_q[0].push_back(pk(1, 0, 7'h58, 144, 35));
        pulse_start(0);
        exp_q[0].push_back(pk(1, 0, 7'h59, 160, 35));
        vs_fall(0, 2); vs_fall(0, 2);
        exp_q[0].push_back(pk(1, 0, 7'h58, 144, 35));
        vs_fall(0, 2); vs_fall(0, 2);
        chk("loop_busy", 32'(busy[0]), 32'd1);
        exp_q[0].push_back(pk(0, 0, 7'h58, 144, 35));
        stp[0] = 1'b1; step(1); stp[0] = 1'b0;
        @(negedge clk);
        chk("stop_busy", 32'(busy[0]), 32'd0);
        chk("stop_done", 32'(done[0]), 32'd0);
        step(3);

        // Line wrap: 41 glyphs, one frame each
        for (int i = 0; i < 41; i++) begin
            wr(1, 7'(8'h21 + i), acc);
        end
        chk("wrap_count", 32'(cnt1), 32'd41);
        exp_q[1].push_back(pk(1, 0, 7'h21, 144, 35));
        for (int i = 1; i < 41; i++) begin
            c = 7'(8'h21 + i);
            exp_q[1].push_back(pk(1, 0, c, 144 + 16 * (i % 40), 35 + 16 * (i / 40)));
        end
        exp_q[1].push_back(pk(0, 1, 7'h49, 144, 51));
        exp_q[1].push_back(pk(0, 0, 7'h49, 144, 51));
        pulse_start(1);
        for (int i = 0; i < 40; i++) vs_fall(1, 2);
        vs_fall(1, 0);
        wait_done(1);

        // Vertical wrap on a two-by-two screen
        for (int i = 0; i < 5; i++) begin
            wr(2, 7'(8'h61 + i), acc);
        end
        for (int i = 0; i < 5; i++) begin
            c = 7'(8'h61 + i);
            exp_q[2].push_back(pk(1, 0, c, xs[i], ys[i]));
        end
        exp_q[2].push_back(pk(0, 1, 7'h65, 144, 35));
        exp_q[2].push_back(pk(0, 0, 7'h65, 144, 35));
        pulse_start(2);
        for (int i = 0; i < 4; i++) vs_fall(2, 2);
        vs_fall(2, 0);
        wait_done(2);

        step(5);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("dut%0d_pending_events", d), 32'(exp_q[d].size()), 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/char_sequencer.md
Name: char_sequencer

Overview:
- Sequencing controller for the single-glyph character display path.
- Holds a short ASCII message in an internal buffer loaded by a host over a valid/ready interface.
- Steps through the message by driving char_sel, x_pos and y_pos, holding each glyph for a programmable number of frames.
- Updates its outputs only at the start of vertical blanking, so a glyph never changes mid-frame.

Parameters:
- DEPTH, 32, message buffer entries (power of 2, 2..64)
- FRAMES_PER_CHAR, 30, frames each glyph is shown (>=1)
- X_START, 144, first active column (h_cnt value)
- Y_START, 35, first active row (v_cnt value)
- X_END, 784, column one past the active area
- Y_END, 515, row one past the active area
- CHAR_W, 16, glyph cell width in pixels
- CHAR_H, 16, glyph cell height in pixels

Ports:
- pix_clk  in  1  pixel clock; only clock
- rst  in  1  asynchronous, active-low reset
- VS_in  in  1  vertical sync from the timing generator; active-low pulse
- wr_valid  in  1  host write request
- wr_char  in  7  ASCII code to append
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- clear  in  1  empty the buffer (IDLE only)
- start  in  1  begin display (IDLE only)
- stop  in  1  abort display
- loop_en  in  1  restart from entry 0 after the last entry
- char_sel  out  7  ASCII code to display
- x_pos  out  10  glyph left column
- y_pos  out  10  glyph top row
- busy  out  1  high while in SHOW
- done  out  1  one-cycle pulse at the end of a non-looping display
- count  out  clog2(DEPTH)+1  number of buffered characters

Behaviour:
- Reset (rst=0, async) values:
  - State IDLE.
  - x_pos=X_START, y_pos=Y_START, char_sel=7'h20.
  - busy=0, done=0, count=0, rd_idx=0, frame_cnt=0.
  - wr_ready=1 once reset is released.
  - Buffer contents are don't-care.
- Frame tick:
  - VS_in is registered once.
  - tick = prev_VS & ~VS_in, i.e. the falling edge. It is asserted for exactly one cycle per frame.
- States: IDLE, SHOW, FINISH.
- IDLE:
  - wr_ready = (count<DEPTH) && !start && !clear. This is combinational.
  - On an accepted write: buf[count]<=wr_char, count<=count+1.
  - clear: count<=0. If clear and start arrive in the same cycle, clear wins and start is ignored.
  - start with count==0 is ignored.
  - start with count>0 takes effect on the next cycle:
    - State SHOW, rd_idx=0, frame_cnt=0.
    - char_sel=buf[0], x_pos=X_START, y_pos=Y_START.
    - busy=1.
- SHOW:
  - wr_ready=0. wr_valid, clear and start are ignored.
  - On tick with frame_cnt<FRAMES_PER_CHAR-1: frame_cnt++.
  - On tick with frame_cnt==FRAMES_PER_CHAR-1: frame_cnt<=0, then advance:
    - If rd_idx<count-1: rd_idx++, char_sel=buf[rd_idx+1], and the position advances.
    - If rd_idx==count-1 and loop_en=1: rd_idx=0, char_sel=buf[0], x_pos=X_START, y_pos=Y_START.
    - If rd_idx==count-1 and loop_en=0: go to FINISH. Outputs hold their last values.
  - Position advance:
    - x_next=x_pos+CHAR_W.
    - If x_next+CHAR_W>X_END: x_pos=X_START and y_next=y_pos+CHAR_H; otherwise x_pos=x_next.
    - On a row wrap, if y_next+CHAR_H>Y_END then y_pos=Y_START, otherwise y_pos=y_next.
  - All output updates land on the cycle after tick.
  - stop (any cycle, priority over advance): next cycle IDLE, busy=0, done stays 0. char_sel, x_pos, y_pos and the buffer hold.
- FINISH: a single cycle. done=1, busy=0. Next state IDLE. count is preserved, so start replays the message.
- Arithmetic: position math uses 11 bits internally; 10-bit outputs never exceed X_END/Y_END. frame_cnt is clog2(FRAMES_PER_CHAR+1) bits.
- Reset mid-operation: immediate return to reset values with no done pulse.

Test Plan:
- Reset: hold rst=0, drive random inputs -> char_sel=0x20, x_pos=144, y_pos=35, busy=0, done=0, count=0. wr_ready=1 on the first cycle after release.
- Basic sequence, FRAMES_PER_CHAR=2: write 0x41, 0x42, 0x43, pulse start, toggle VS_in -> 0x41@(144,35). After 2 VS falls, 0x42@(160,35). After 2 more, 0x43@(176,35). After 2 more, done high for exactly 1 cycle, busy=0, count=3.
- Full buffer: perform 32 accepted writes -> count=32, wr_ready=0. A 33rd wr_valid is not accepted and count stays 32.
- Line and screen wrap, DEPTH=64, FRAMES_PER_CHAR=1: 40 glyphs land at x=144..768 step 16 with y=35. Glyph 41 lands at (144,51).
- Vertical wrap: with Y_END=67, a wrap from the row at y=51 goes to (144,35).
- Loop and stop: loop_en=1 with 2 chars -> after the 2nd glyph, buf[0] at (144,35), busy stays 1, no done. Assert stop -> IDLE next cycle, busy=0, done=0.
- Edge priorities: start with count=0 -> stays IDLE. clear+start together with count=5 -> count=0, IDLE. A VS falling edge during IDLE has no effect on any output.
